multi_pulser: RTL

Multi-channel programmable pulse-train generator; parametrised successor to the fixed single-output pulser. Each of N_CH channels runs its own period/width counter with runtime-loadable configuration, start/stop control and continuous or one-shot mode. It drives game tick, blink and timeout strobes from one clock domain.

---
 rtl/multi_pulser.sv | 73 +++++++
 1 files changed

// File: rtl/multi_pulser.sv
// multi_pulser: N_CH independent programmable pulse-train generators with shadow/active config and one-shot mode
module multi_pulser #(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned DEF_PERIOD = 25000000,
  parameter int unsigned DEF_WIDTH  = 10000000,
  localparam int unsigned CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_width,
  input  logic             cfg_oneshot,
  input  logic [N_CH-1:0]  start,
  input  logic [N_CH-1:0]  stop,
  output logic [N_CH-1:0]  p,
  output logic [N_CH-1:0]  busy,
  output logic [N_CH-1:0]  done
);
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [CNT_W-1:0] r_sp, r_sw, r_ap, r_aw, r_cnt, w_np, w_nw;
    logic             r_so, r_ao, r_run, r_p, r_done, w_no;
    logic             w_we, w_start, w_last, w_wrap;
    assign w_we    = cfg_we && (cfg_ch == CH_W'(c));
    assign w_np    = w_we ? cfg_period  : r_sp;
    assign w_nw    = w_we ? cfg_width   : r_sw;
    assign w_no    = w_we ? cfg_oneshot : r_so;
    assign w_start = start[c] && !stop[c];
    // period 0 behaves as period 1, so the last count is 0 in both cases
    assign w_last  = r_cnt == ((r_ap == '0) ? '0 : r_ap - 1'b1);
    assign w_wrap  = r_run && w_last && !start[c] && !stop[c];
    assign p[c]    = r_p;
    assign busy[c] = r_run;
    assign done[c] = r_done;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_sp   <= CNT_W'(DEF_PERIOD);
        r_sw   <= CNT_W'(DEF_WIDTH);
        r_so   <= 1'b0;
        r_ap   <= CNT_W'(DEF_PERIOD);
        r_aw   <= CNT_W'(DEF_WIDTH);
        r_ao   <= 1'b0;
        r_cnt  <= '0;
        r_run  <= 1'b0;
        r_p    <= 1'b0;
        r_done <= 1'b0;
      end else begin
        r_sp   <= w_np;
        r_sw   <= w_nw;
        r_so   <= w_no;
        r_p    <= r_run && (r_cnt < r_aw);
        r_done <= w_wrap && r_ao;
        if (stop[c]) begin
          r_run <= 1'b0;
          r_cnt <= '0;
        end else if (w_start || (w_wrap && !r_ao)) begin
          r_run <= 1'b1;
          r_cnt <= '0;
          r_ap  <= w_np;
          r_aw  <= w_nw;
          r_ao  <= w_no;
        end else if (w_wrap) begin
          r_run <= 1'b0;
          r_cnt <= '0;
        end else if (r_run) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end
endmodule
